text_mode_renderer: RTL and testbench

- Text-mode pixel generator for the VDP. It sits between the hvsync timing generator and the video output, and uses the 8x8 ASCII font ROM as its glyph source.
- For each 8-pixel character cell it fetches a 16-bit cell word from screen RAM, looks up one glyph row in the font ROM, and serialises that row into 4-bit colour indices.
- Output is delayed by a fixed pipeline latency that the top level compensates for on hsync/vsync.

---
 rtl/vdp_pkg.sv | 15 +
 rtl/text_cell_shifter.sv | 52 +++++
 rtl/text_mode_renderer.sv | 106 ++++++++++
 tb/tb_text_mode_renderer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/vdp_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | vdp_pkg : shared constants for the VDP text-mode path                 |
// | Rev 1.0 : initial release                                             |
// +-----------------------------------------------------------------------+
package vdp_pkg;
  localparam int CELL_W        = 8;
  localparam int GLYPH_H       = 8;
  localparam int CODE_LSB      = 0;
  localparam int FG_LSB        = 8;
  localparam int BG_LSB        = 12;
  localparam int PIXEL_LATENCY = 9;
  localparam int CI_W          = 4;
endpackage
`default_nettype wire

// File: rtl/text_cell_shifter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | text_cell_shifter : glyph row serialiser with fg/bg select            |
// | Rev 1.0 : initial release                                             |
// +-----------------------------------------------------------------------+
module text_cell_shifter
  import vdp_pkg::*;
#(
  parameter logic [CI_W-1:0] BORDER = 4'h0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [CELL_W-1:0] pat,
  input  logic [CI_W-1:0]   fg,
  input  logic [CI_W-1:0]   bg,
  input  logic              valid,
  output logic [CI_W-1:0]   pix_colour,
  output logic              pix_active
);

  logic [CELL_W-1:0] shifter;
  logic [CI_W-1:0]   fg_a;
  logic [CI_W-1:0]   bg_a;
  logic              act;

  // The output register sees the pre-load state, so a cell loaded on the
  // edge ending p==7 drives its first pixel one edge later.
  always_ff @(posedge clk) begin
    if (reset) begin
      shifter    <= '0;
      fg_a       <= '0;
      bg_a       <= '0;
      act        <= 1'b0;
      pix_colour <= BORDER;
      pix_active <= 1'b0;
    end else begin
      pix_colour <= act ? (shifter[CELL_W-1] ? fg_a : bg_a) : BORDER;
      pix_active <= act;
      if (load) begin
        shifter <= pat;
        fg_a    <= fg;
        bg_a    <= bg;
        act     <= valid;
      end else begin
        shifter <= {shifter[CELL_W-2:0], 1'b0};
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/text_mode_renderer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | text_mode_renderer : screen RAM + font ROM fetch, 8-pixel serialiser  |
// | Rev 1.0 : initial release                                             |
// +-----------------------------------------------------------------------+
module text_mode_renderer
  import vdp_pkg::*;
#(
  parameter int               COLS   = 32,
  parameter int               ROWS   = 24,
  parameter int               ADDR_W = 10,
  parameter logic [CI_W-1:0]  BORDER = 4'h0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [8:0]        hpos,
  input  logic [8:0]        vpos,
  input  logic              display_on,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_re,
  input  logic [15:0]       ram_data,
  output logic [7:0]        font_code,
  output logic [2:0]        font_yofs,
  input  logic [7:0]        font_bits,
  output logic [CI_W-1:0]   pix_colour,
  output logic              pix_active
);

  localparam logic [8:0] COLS_V = 9'(COLS);
  localparam logic [8:0] ROWS_V = 9'(ROWS);

  logic [2:0]        p;
  logic [5:0]        col;
  logic [5:0]        row;
  logic              cell_ok;
  logic [ADDR_W-1:0] cell_addr;

  assign p         = hpos[2:0];
  assign col       = hpos[8:3];
  assign row       = vpos[8:3];
  assign cell_ok   = display_on && ({3'b000, col} < COLS_V) && ({3'b000, row} < ROWS_V);
  assign cell_addr = ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);

  logic              valid_s1;
  logic              valid_s2;
  logic              valid_q;
  logic [CI_W-1:0]   fg_s2;
  logic [CI_W-1:0]   bg_s2;
  logic [CI_W-1:0]   fg_q;
  logic [CI_W-1:0]   bg_q;
  logic [CELL_W-1:0] pat_q;

  // Fetch pipeline: address at p0, RAM data at p2, font row at p3.
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_addr  <= '0;
      ram_re    <= 1'b0;
      valid_s1  <= 1'b0;
      font_code <= '0;
      font_yofs <= '0;
      fg_s2     <= '0;
      bg_s2     <= '0;
      valid_s2  <= 1'b0;
      pat_q     <= '0;
      fg_q      <= '0;
      bg_q      <= '0;
      valid_q   <= 1'b0;
    end else begin
      if (p == 3'd0) begin
        valid_s1 <= cell_ok;
        ram_re   <= cell_ok;
        if (cell_ok) ram_addr <= cell_addr;
      end
      if (p == 3'd2) begin
        font_code <= ram_data[CODE_LSB +: 8];
        font_yofs <= vpos[2:0];
        fg_s2     <= ram_data[FG_LSB +: CI_W];
        bg_s2     <= ram_data[BG_LSB +: CI_W];
        valid_s2  <= valid_s1;
      end
      if (p == 3'd3) begin
        pat_q   <= font_bits;
        fg_q    <= fg_s2;
        bg_q    <= bg_s2;
        valid_q <= valid_s2;
        ram_re  <= 1'b0;
      end
    end
  end

  text_cell_shifter #(
    .BORDER (BORDER)
  ) u_shifter (
    .clk        (clk),
    .reset      (reset),
    .load       (p == 3'd7),
    .pat        (pat_q),
    .fg         (fg_q),
    .bg         (bg_q),
    .valid      (valid_q),
    .pix_colour (pix_colour),
    .pix_active (pix_active)
  );

endmodule
`default_nettype wire

// File: tb/tb_text_mode_renderer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_text_mode_renderer : bench with screen RAM / font ROM models       |
// | Rev 1.0 : initial release                                             |
// +-----------------------------------------------------------------------+
module tb_text_mode_renderer;

  localparam int COLS    = 32;
  localparam int ROWS    = 24;
  localparam int H_TOTAL = 320;
  localparam logic [3:0] BORDER = 4'h0;

  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  hpos;
  logic [8:0]  vpos;
  logic        display_on;
  logic [9:0]  ram_addr;
  logic        ram_re;
  logic [15:0] ram_data = '0;
  logic [7:0]  font_code;
  logic [2:0]  font_yofs;
  logic [7:0]  font_bits;
  logic [3:0]  pix_colour;
  logic        pix_active;

  logic [15:0] mem  [0:1023];
  logic [7:0]  font [0:2047];
  logic [3:0]  seq  [8] = '{4'hF, 4'hF, 4'h2, 4'h2, 4'h2, 4'h2, 4'hF, 4'hF};

  int passes = 0;
  int fails  = 0;
  int total  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_re) ram_data <= mem[ram_addr];
  assign font_bits = font[{font_code, font_yofs}];

  text_mode_renderer #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .ADDR_W (10),
    .BORDER (BORDER)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .hpos       (hpos),
    .vpos       (vpos),
    .display_on (display_on),
    .ram_addr   (ram_addr),
    .ram_re     (ram_re),
    .ram_data   (ram_data),
    .font_code  (font_code),
    .font_yofs  (font_yofs),
    .font_bits  (font_bits),
    .pix_colour (pix_colour),
    .pix_active (pix_active)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One scan line; outputs are checked mid-cycle against what the cell
  // rules predict for the current hpos, then the clock advances.
  task automatic run_line(input int v, input int mode, input int rst_at);
    bit          disp_at [40];
    int          last_rst;
    int          c, p, x, xc;
    bit          exp_re, exp_act;
    logic [15:0] word;
    logic [7:0]  bits;
    logic [3:0]  exp_pix;
    last_rst = -100;
    for (int i = 0; i < 40; i++) disp_at[i] = 1'b0;
    for (int h = 0; h < H_TOTAL; h++) begin
      hpos = 9'(h);
      vpos = 9'(v);
      case (mode)
        0:       display_on = (h < 256);
        1:       display_on = ($urandom_range(0, 3) != 0);
        default: display_on = 1'b1;
      endcase
      reset = (h == rst_at);
      if (h % 8 == 0) disp_at[h / 8] = display_on;

      c = h / 8;
      p = h % 8;
      exp_re = (p >= 1) && (p <= 3) && disp_at[c] && (c < COLS) && (v / 8 < ROWS) && (last_rst < 8 * c);
      check($sformatf("ram_re h=%0d v=%0d", h, v), 16'(ram_re), 16'(exp_re));
      if (exp_re)
        check($sformatf("ram_addr h=%0d v=%0d", h, v), 16'(ram_addr), 16'((v / 8) * COLS + c));
      if (exp_re && p == 3) begin
        word = mem[(v / 8) * COLS + c];
        check($sformatf("font_code h=%0d v=%0d", h, v), 16'(font_code), 16'(word[7:0]));
        check($sformatf("font_yofs h=%0d v=%0d", h, v), 16'(font_yofs), 16'(v % 8));
      end

      exp_act = 1'b0;
      exp_pix = BORDER;
      if (h >= 9) begin
        x  = h - 9;
        xc = x / 8;
        if (disp_at[xc] && xc < COLS && v / 8 < ROWS && last_rst < 8 * xc) begin
          word    = mem[(v / 8) * COLS + xc];
          bits    = font[int'(word[7:0]) * 8 + v % 8];
          exp_act = 1'b1;
          exp_pix = bits[7 - x % 8] ? word[11:8] : word[15:12];
        end
      end
      check($sformatf("pix_active h=%0d v=%0d", h, v), 16'(pix_active), 16'(exp_act));
      check($sformatf("pix_colour h=%0d v=%0d", h, v), 16'(pix_colour), 16'(exp_pix));

      if (v == 3 && h >= 9 && h <= 16)
        check($sformatf("cell0_seq h=%0d", h), 16'(pix_colour), 16'(seq[h - 9]));
      if (v == 3 && h == 3) begin
        check("cell0_font_code", 16'(font_code), 16'h0041);
        check("cell0_font_yofs", 16'(font_yofs), 16'd3);
      end
      if (v == 3 && h == 265)
        check("after_last_col_active", 16'(pix_active), 16'd0);
      if (v == 17 && h == 41)
        check("row2_col5_addr", 16'(ram_addr), 16'd69);
      if (v == 17 && h >= 41 && h <= 43)
        check($sformatf("row2_col5_re h=%0d", h), 16'(ram_re), 16'd1);
      if (rst_at >= 0 && h == rst_at + 1) begin
        check("midreset_font_code", 16'(font_code), 16'd0);
        check("midreset_active", 16'(pix_active), 16'd0);
      end

      @(posedge clk);
      #1;
      if (reset) last_rst = h;
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 2048; i++) font[i] = 8'($urandom);
    mem[0] = 16'h2F41;
    font[8'h41 * 8 + 3] = 8'b1100_0011;

    reset      = 1'b1;
    hpos       = '0;
    vpos       = '0;
    display_on = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst_ram_addr", 16'(ram_addr), 16'd0);
      check("rst_ram_re", 16'(ram_re), 16'd0);
      check("rst_font_code", 16'(font_code), 16'd0);
      check("rst_font_yofs", 16'(font_yofs), 16'd0);
      check("rst_pix_colour", 16'(pix_colour), 16'(BORDER));
      check("rst_pix_active", 16'(pix_active), 16'd0);
    end
    reset = 1'b0;

    run_line(0, 0, -1);
    run_line(3, 0, -1);
    run_line(17, 0, -1);
    run_line(192, 2, -1);
    run_line(5, 0, 12);
    run_line(6, 0, -1);
    for (int i = 0; i < 8; i++)
      run_line(int'($urandom_range(0, 199)), int'($urandom_range(0, 2)), -1);
    run_line(int'($urandom_range(0, 191)), 0, int'($urandom_range(0, 300)));
    run_line(int'($urandom_range(0, 191)), 1, -1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
`default_nettype wire
